pc_stack_bh: RTL and testbench
==============================

Name: pc_stack_bh

Overview:
Parametrised program counter for the SAP-2/SAP-3 generation.
- Generalises the SAP-1 counter to WIDTH bits.
- Adds a parallel load for jumps and a hardware return-address stack for CALL/RET.
- Sits between the controller-sequencer and the memory address register. Q drives the address path; D comes from the W-bus.

Parameters:
WIDTH, 8, counter/address width in bits (>=2)
DEPTH, 4, return-stack entries (>=1, power of two not required)
RESET_VAL, 0, value loaded into Q on reset

Ports:
CLK_BAR  input  1  system clock; all state changes on the falling edge
CLR_BAR  input  1  asynchronous active-low reset
COUNT  input  1  increment Q
LOAD  input  1  jump: Q <= D
CALL  input  1  push Q+1, then Q <= D
RET  input  1  pop top of stack into Q
D  input  WIDTH  jump/call target from W-bus
Q  output  WIDTH  current program counter
STK_EMPTY  output  1  stack holds zero entries
STK_FULL  output  1  stack holds DEPTH entries
STK_OVF  output  1  sticky: CALL attempted while full
STK_UNF  output  1  sticky: RET attempted while empty

Behaviour:
- Clock and reset: one clock, CLK_BAR; state updates on negedge CLK_BAR. CLR_BAR is asynchronous and active-low; its assertion takes effect immediately.
- Reset values: Q=RESET_VAL, stack pointer=0, STK_EMPTY=1, STK_FULL=0, STK_OVF=0, STK_UNF=0. Stack storage contents are don't-care.
- Latency: every command takes effect at the falling edge where it is sampled. Q is visible immediately after that edge; no pipeline.
- Command priority per edge, highest first: RET > CALL > LOAD > COUNT. Lower commands asserted at the same edge are ignored. No command asserted: all state held.
- COUNT: Q <= Q+1 mod 2^WIDTH. All-ones wraps to 0.
- LOAD: Q <= D. Stack untouched.
- CALL, not full: stack[sp] <= Q+1 mod 2^WIDTH; sp <= sp+1; Q <= D.
- CALL, full: Q, sp and stack are held. STK_OVF <= 1.
- RET, not empty: Q <= stack[sp-1]; sp <= sp-1.
- RET, empty: Q and sp are held. STK_UNF <= 1.
- STK_EMPTY = (sp==0) and STK_FULL = (sp==DEPTH). Both are combinational from the registered sp.
- sp width is clog2(DEPTH+1).
- STK_OVF and STK_UNF are sticky. Only CLR_BAR clears them.
- Reset mid-operation: CLR_BAR low overrides any command at the same edge. The in-flight push or pop is discarded.
- Outputs are never X after reset. Unknown commands (X) are not required to be handled.

Optional Feature:
Macro PC_STACK_EN.
- Defined: return stack, CALL/RET and all STK_* outputs behave as above.
- Undefined: no stack storage is built.
  - CALL behaves exactly as LOAD (Q <= D, no push).
  - RET is ignored.
  - STK_EMPTY tied 1; STK_FULL, STK_OVF and STK_UNF tied 0.
- Priority among LOAD/COUNT/CALL is unchanged.

Test Plan:
1. Reset and count (WIDTH=8, RESET_VAL=0): release CLR_BAR, COUNT high for 258 edges -> Q runs 1..255, 0, 1, 2 (wrap at 255->0); no flags set.
2. Jump vs count: Q=0x10, LOAD=1, COUNT=1, D=0x80 -> Q=0x80; next edge COUNT only -> Q=0x81.
3. Nested call/return (DEPTH=4): Q=0x05, CALL D=0x40 -> Q=0x40, STK_EMPTY=0. CALL D=0x60 -> Q=0x60. RET -> Q=0x41. RET -> Q=0x06, STK_EMPTY=1.
4. Overflow/underflow: 4 CALLs -> STK_FULL=1. 5th CALL D=0xAA -> Q unchanged, STK_OVF=1. 4 RETs -> STK_EMPTY=1. 5th RET -> Q unchanged, STK_UNF=1. Both flags persist until CLR_BAR low.
5. Async reset mid-call: with sp=2, assert CLR_BAR between edges -> Q=RESET_VAL and STK_EMPTY=1 immediately, without waiting for a clock edge. A CALL held over the reset edge has no effect.
6. PC_STACK_EN undefined: Q=0x05, CALL D=0x40 -> Q=0x40. Then RET -> Q stays 0x40; STK_EMPTY=1, all other STK_* outputs 0.

Source files
------------

// File: rtl/pc_stack_bh.sv
// pc_stack_bh: SAP-2/SAP-3 program counter with parallel load and a return-address stack.
// All state changes on the falling edge of CLK_BAR. CLR_BAR is an asynchronous active-low clear.
// Optional feature macro: PC_STACK_EN builds the return stack and enables CALL push / RET pop.
// Without it, CALL acts as LOAD, RET is ignored and the STK_* outputs are tied off.
module pc_stack_bh #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK_BAR,
    input  logic             CLR_BAR,
    input  logic             COUNT,
    input  logic             LOAD,
    input  logic             CALL,
    input  logic             RET,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             STK_EMPTY,
    output logic             STK_FULL,
    output logic             STK_OVF,
    output logic             STK_UNF
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_inc;

    assign q_inc = q_q + WIDTH'(1);
    assign Q     = q_q;

`ifdef PC_STACK_EN
    localparam int unsigned SpW  = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SpW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic             empty, full;
    logic [IdxW-1:0]  wr_idx, rd_idx;
    logic [WIDTH-1:0] stack_q [DEPTH];

    assign empty  = (sp_q == '0);
    assign full   = (sp_q == SpW'(DEPTH));
    assign wr_idx = IdxW'(sp_q);
    assign rd_idx = IdxW'(sp_q - SpW'(1));

    assign STK_EMPTY = empty;
    assign STK_FULL  = full;
    assign STK_OVF   = ovf_q;
    assign STK_UNF   = unf_q;

    // Next-state decode with priority RET > CALL > LOAD > COUNT.
    always_comb begin
        q_d   = q_q;
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (RET) begin
            if (!empty) begin
                q_d  = stack_q[rd_idx];
                sp_d = sp_q - SpW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else if (CALL) begin
            if (!full) begin
                push = 1'b1;
                sp_d = sp_q + SpW'(1);
                q_d  = D;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (LOAD) begin
            q_d = D;
        end else if (COUNT) begin
            q_d = q_inc;
        end
    end

    // Stack pointer and sticky error flags; cleared only by CLR_BAR.
    always_ff @(negedge CLK_BAR or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; no reset needed, a push held over a clear is dropped.
    always_ff @(negedge CLK_BAR) begin
        if (push && CLR_BAR) begin
            stack_q[wr_idx] <= q_inc;
        end
    end
`else
    logic unused_ret;

    assign unused_ret = RET;

    assign STK_EMPTY = 1'b1;
    assign STK_FULL  = 1'b0;
    assign STK_OVF   = 1'b0;
    assign STK_UNF   = 1'b0;

    // Next-state decode without a stack: CALL is a plain jump, RET has no effect.
    always_comb begin
        q_d = q_q;
        if (CALL || LOAD) begin
            q_d = D;
        end else if (COUNT) begin
            q_d = q_inc;
        end
    end
`endif

    // Program counter register.
    always_ff @(negedge CLK_BAR or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: tb/tb_pc_stack_bh.sv
// tb_pc_stack_bh: directed bench for pc_stack_bh (WIDTH=8, DEPTH=4, RESET_VAL=0).
// Stack-specific vectors run only when PC_STACK_EN is defined; otherwise the tie-offs are checked.
module tb_pc_stack_bh;

    logic       clk_bar;
    logic       clr_bar;
    logic       count, load, call, ret;
    logic [7:0] d;
    logic [7:0] q;
    logic       stk_empty, stk_full, stk_ovf, stk_unf;

    int n_checks;
    int n_errors;

    pc_stack_bh #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .CLK_BAR   (clk_bar),
        .CLR_BAR   (clr_bar),
        .COUNT     (count),
        .LOAD      (load),
        .CALL      (call),
        .RET       (ret),
        .D         (d),
        .Q         (q),
        .STK_EMPTY (stk_empty),
        .STK_FULL  (stk_full),
        .STK_OVF   (stk_ovf),
        .STK_UNF   (stk_unf)
    );

    initial clk_bar = 1'b1;
    always #5 clk_bar = ~clk_bar;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one command set and advance past the next falling edge.
    task automatic step(input logic c, input logic l, input logic k, input logic r,
                        input logic [7:0] dv);
        count = c;
        load  = l;
        call  = k;
        ret   = r;
        d     = dv;
        @(negedge clk_bar);
        #1;
        count = 1'b0;
        load  = 1'b0;
        call  = 1'b0;
        ret   = 1'b0;
    endtask

    function automatic logic [3:0] flags();
        return {stk_empty, stk_full, stk_ovf, stk_unf};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr_bar  = 1'b0;
        count    = 1'b0;
        load     = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        d        = 8'h00;

        #3;
        check("reset_q", q, 8'h00);
        check("reset_flags", flags(), 4'b1000);
        @(negedge clk_bar);
        #1;
        clr_bar = 1'b1;

        // Count through the full range and wrap.
        for (int i = 0; i < 258; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            check("count", q, 32'((i + 1) % 256));
        end
        check("count_flags", flags(), 4'b1000);

        // LOAD beats COUNT, then plain count and hold.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        check("load_10", q, 8'h10);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
        check("load_over_count", q, 8'h80);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("count_after_load", q, 8'h81);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        check("hold", q, 8'h81);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("wrap_after_load", q, 8'h00);

`ifdef PC_STACK_EN
        // Nested call/return with priority checks.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
        check("call1_q", q, 8'h40);
        check("call1_empty", stk_empty, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h60);
        check("call2_q", q, 8'h60);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
        check("ret1_q", q, 8'h41);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("ret2_q", q, 8'h06);
        check("ret2_flags", flags(), 4'b1000);

        // Fill, overflow, drain, underflow.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'((i + 2) * 16));
            check("fill_q", q, 32'((i + 2) * 16));
        end
        check("full_flags", flags(), 4'b0100);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hAA);
        check("ovf_q", q, 8'h50);
        check("ovf_flags", flags(), 4'b0110);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            check("drain_q", q, 32'(8'h41 - 8'(i * 16)));
        end
        check("drained_flags", flags(), 4'b1010);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("unf_q", q, 8'h11);
        check("unf_flags", flags(), 4'b1011);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
        check("sticky_q", q, 8'h33);
        check("sticky_flags", flags(), 4'b1011);

        // Clear, then build sp=2 for the mid-call reset.
        #2;
        clr_bar = 1'b0;
        #1;
        check("clr_flags", flags(), 4'b1000);
        @(negedge clk_bar);
        #1;
        clr_bar = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h60);
        check("sp2_q", q, 8'h60);
        check("sp2_flags", flags(), 4'b0000);
`else
        // Without the stack: CALL is a jump, RET does nothing.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
        check("call_as_load", q, 8'h40);
        check("call_flags", flags(), 4'b1000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("ret_ignored", q, 8'h40);
        check("ret_flags", flags(), 4'b1000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
        check("call_over_count", q, 8'h22);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("count_after_call", q, 8'h23);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h60);
        check("pre_reset_q", q, 8'h60);
`endif

        // Asynchronous clear between edges with a CALL held over the clock edge.
        #2;
        call    = 1'b1;
        load    = 1'b1;
        count   = 1'b1;
        d       = 8'h77;
        clr_bar = 1'b0;
        #1;
        check("async_q", q, 8'h00);
        check("async_flags", flags(), 4'b1000);
        @(negedge clk_bar);
        #1;
        check("held_q", q, 8'h00);
        check("held_flags", flags(), 4'b1000);
        call    = 1'b0;
        load    = 1'b0;
        count   = 1'b0;
        clr_bar = 1'b1;

`ifdef PC_STACK_EN
        // The discarded stack must read as empty.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("post_reset_ret_q", q, 8'h00);
        check("post_reset_ret_flags", flags(), 4'b1001);
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("post_reset_count", q, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
